// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - command/ALU-op encodings, FSM states and decode helpers for alu_cmd_sequencer
package alu_seq_pkg;

    localparam logic [2:0] CMD_AND = 3'b000;
    localparam logic [2:0] CMD_OR  = 3'b001;
    localparam logic [2:0] CMD_ADD = 3'b010;
    localparam logic [2:0] CMD_SUB = 3'b011;
    localparam logic [2:0] CMD_SLT = 3'b100;
    localparam logic [2:0] CMD_MUL = 3'b101;

    localparam logic [1:0] ALUOP_AND = 2'b00;
    localparam logic [1:0] ALUOP_OR  = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic cmd_legal(input logic [2:0] cmd);
`ifdef ALU_SEQ_MUL_EN
        return cmd <= CMD_MUL;
`else
        return cmd <= CMD_SLT;
`endif
    endfunction

    // SUB and SLT both run as A + ~B + 1 through the adder
    function automatic logic cmd_is_sub(input logic [2:0] cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

    function automatic logic [1:0] cmd_aluop(input logic [2:0] cmd);
        case (cmd)
            CMD_AND: return ALUOP_AND;
            CMD_OR:  return ALUOP_OR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// rtl/alu_seq_flags.sv - combinational result mux and zero/carry/overflow/slt flags
module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       cmd_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic             alu_cout_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             slt_o
);

    logic ovf_add;
    logic ovf_sub;

    // b_i is the un-inverted operand, so the sign tests read naturally
    assign ovf_add = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_res_i[WIDTH-1] != a_i[WIDTH-1]);
    assign ovf_sub = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_res_i[WIDTH-1] != a_i[WIDTH-1]);
    assign slt_o   = alu_res_i[WIDTH-1] ^ ovf_sub;

    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (cmd_i)
            CMD_AND, CMD_OR: res_o = alu_res_i;
            CMD_ADD: begin
                res_o   = alu_res_i;
                carry_o = alu_cout_i;
                ovf_o   = ovf_add;
            end
            CMD_SUB: begin
                res_o   = alu_res_i;
                carry_o = alu_cout_i;
                ovf_o   = ovf_sub;
            end
            CMD_SLT: res_o = {{(WIDTH-1){1'b0}}, slt_o};
            CMD_MUL: res_o = a_i;
            default: res_o = '0;
        endcase
    end

    assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - ALU command sequencer; ALU_SEQ_MUL_EN enables iterative shift-add MUL
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_binvert,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err
);

    if (2**CNT_W <= WIDTH) begin : g_cnt_w_check
        $error("CNT_W too small for WIDTH iterations");
    end

    state_t           state_q, state_d;
    logic [2:0]       cmd_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [1:0]       alu_op_q;
    logic             alu_binv_q;
    logic [WIDTH-1:0] out_res_q;
    logic             out_zero_q, out_carry_q, out_ovf_q, out_err_q;

    logic [WIDTH-1:0] fl_a, fl_res;
    logic             fl_zero, fl_carry, fl_ovf, fl_slt_unused;

`ifdef ALU_SEQ_MUL_EN
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_d;
    logic             mul_last;

    // During MUL alu_a_q is the accumulator, alu_b_q the multiplicand and b_q the multiplier
    assign acc_d    = b_q[0] ? alu_res : alu_a_q;
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign fl_a     = (state_q == MUL) ? acc_d : a_q;
`else
    assign fl_a     = a_q;
`endif

    alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
        .cmd_i      (cmd_q),
        .a_i        (fl_a),
        .b_i        (b_q),
        .alu_res_i  (alu_res),
        .alu_cout_i (alu_cout),
        .res_o      (fl_res),
        .zero_o     (fl_zero),
        .carry_o    (fl_carry),
        .ovf_o      (fl_ovf),
        .slt_o      (fl_slt_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) begin
                if (!cmd_legal(in_cmd))       state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
                else if (in_cmd == CMD_MUL)   state_d = MUL;
`endif
                else                          state_d = EXEC;
            end
            EXEC: state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
            MUL:  if (mul_last) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALUOP_AND;
            alu_binv_q  <= 1'b0;
            out_res_q   <= '0;
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    cmd_q <= in_cmd;
                    a_q   <= in_a;
                    b_q   <= in_b;
                    if (!cmd_legal(in_cmd)) begin
                        out_res_q   <= '0;
                        out_zero_q  <= 1'b1;
                        out_carry_q <= 1'b0;
                        out_ovf_q   <= 1'b0;
                        out_err_q   <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    end else if (in_cmd == CMD_MUL) begin
                        alu_a_q    <= '0;
                        alu_b_q    <= in_a;
                        alu_op_q   <= ALUOP_ADD;
                        alu_binv_q <= 1'b0;
                        cnt_q      <= '0;
`endif
                    end else begin
                        alu_a_q    <= in_a;
                        alu_b_q    <= cmd_is_sub(in_cmd) ? ~in_b : in_b;
                        alu_op_q   <= cmd_aluop(in_cmd);
                        alu_binv_q <= cmd_is_sub(in_cmd);
                    end
                end
                EXEC: begin
                    out_res_q   <= fl_res;
                    out_zero_q  <= fl_zero;
                    out_carry_q <= fl_carry;
                    out_ovf_q   <= fl_ovf;
                    out_err_q   <= 1'b0;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    alu_a_q <= acc_d;
                    alu_b_q <= alu_b_q << 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (mul_last) begin
                        out_res_q   <= fl_res;
                        out_zero_q  <= fl_zero;
                        out_carry_q <= fl_carry;
                        out_ovf_q   <= fl_ovf;
                        out_err_q   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_binvert = alu_binv_q;
    assign alu_cin     = 1'b0;
    assign out_res     = out_res_q;
    assign out_zero    = out_zero_q;
    assign out_carry   = out_carry_q;
    assign out_ovf     = out_ovf_q;
    assign out_err     = out_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed table-driven bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    localparam int W = 32;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [2:0]   in_cmd;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic [1:0]   alu_op;
    logic         alu_binvert, alu_cin, alu_cout;
    logic         out_valid, out_ready;
    logic [W-1:0] out_res;
    logic         out_zero, out_carry, out_ovf, out_err;

    int checks = 0;
    int errors = 0;
    logic saw_op11 = 1'b0;

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_binvert(alu_binvert), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: alu_res = alu_a & alu_b;
            2'b01: alu_res = alu_a | alu_b;
            2'b10: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_binvert};
            default: alu_res = '0;
        endcase
    end

    always @(posedge clk) if (alu_op == 2'b11) saw_op11 = 1'b1;

    typedef struct {
        logic [2:0]   cmd;
        logic [W-1:0] a, b, res;
        logic         zero, carry, ovf, err;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v, input string name);
        int lat;
        bit got;
        @(negedge clk);
        in_valid = 1'b1; in_cmd = v.cmd; in_a = v.a; in_b = v.b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1;
        end
        chk({name, ".lat"}, W'(lat), W'(v.lat));
        chk({name, ".res"}, out_res, v.res);
        chk({name, ".zero"}, W'(out_zero), W'(v.zero));
        chk({name, ".carry"}, W'(out_carry), W'(v.carry));
        chk({name, ".ovf"}, W'(out_ovf), W'(v.ovf));
        chk({name, ".err"}, W'(out_err), W'(v.err));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic z, input logic c,
                                input logic o, input logic e, input int lat);
        vec_t v;
        v.cmd = cmd; v.a = a; v.b = b; v.res = res;
        v.zero = z; v.carry = c; v.ovf = o; v.err = e; v.lat = lat;
        return v;
    endfunction

    vec_t vecs[$];
    vec_t v;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

        vecs.push_back(mk(3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b010, 32'd2,        32'd3,        32'd5,        0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1, 0, 0, 2));
        vecs.push_back(mk(3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 1, 0, 2));
        vecs.push_back(mk(3'b011, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 1, 1, 0, 2));
        vecs.push_back(mk(3'b011, 32'd5,        32'd5,        32'd0,        1, 1, 0, 0, 2));
        vecs.push_back(mk(3'b011, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b100, 32'h80000000, 32'd1,        32'd1,        0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b100, 32'd5,        32'd3,        32'd0,        1, 0, 0, 0, 2));
        vecs.push_back(mk(3'b100, 32'd3,        32'd5,        32'd1,        0, 0, 0, 0, 2));
        vecs.push_back(mk(3'b110, 32'd9,        32'd9,        32'd0,        1, 0, 0, 1, 1));
        vecs.push_back(mk(3'b111, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 0, 1, 1));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk(3'b101, 32'd7,        32'd6,        32'd42,       0, 0, 0, 0, W + 1));
        vecs.push_back(mk(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 0, W + 1));
        vecs.push_back(mk(3'b101, 32'd0,        32'd5,        32'd0,        1, 0, 0, 0, W + 1));
`else
        vecs.push_back(mk(3'b101, 32'd7,        32'd6,        32'd0,        1, 0, 0, 1, 1));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", W'(in_ready), W'(1));
        chk("rst.out_valid", W'(out_valid), W'(0));
        chk("rst.out_res", out_res, '0);
        chk("rst.flags", W'({out_zero, out_carry, out_ovf, out_err}), W'(0));
        chk("rst.alu_a", alu_a, '0);
        chk("rst.alu_b", alu_b, '0);
        chk("rst.alu_ctl", W'({alu_op, alu_binvert, alu_cin}), W'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result must hold while out_ready is low, new commands refused
        run_cmd_start:
        @(negedge clk);
        in_valid = 1'b1; in_cmd = 3'b000; in_a = 32'h0000F0F0; in_b = 32'h0000FF00;
        @(posedge clk); #1;
        in_cmd = 3'b001; in_a = 32'h1234; in_b = 32'h5678;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp.valid%0d", c), W'(out_valid), W'(1));
            chk($sformatf("bp.in_ready%0d", c), W'(in_ready), W'(0));
            chk($sformatf("bp.res%0d", c), out_res, 32'h0000F000);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle", W'({in_ready, out_valid}), W'(2'b10));
        run_cmd(mk(3'b001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0, 0, 0, 0, 2), "bp.or");

        // Asynchronous reset in the middle of a command
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        in_valid = 1'b1; in_cmd = 3'b101; in_a = 32'd7; in_b = 32'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
`else
        in_valid = 1'b1; in_cmd = 3'b010; in_a = 32'd2; in_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
`endif
        chk("mid.busy", W'(in_ready), W'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("mid.out_valid", W'(out_valid), W'(0));
        chk("mid.in_ready", W'(in_ready), W'(1));
        chk("mid.out_res", out_res, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(mk(3'b010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 2), "post_rst.add");

        chk("alu_op_never_11", W'(saw_op11), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
